mem_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage in the RISC-V core. Consumes the registered ALU result (effective address or computed value) and the instruction fields, performs loads and stores over a valid/ready data-memory port, and hands write-back data to the final stage. It stalls upstream stages while a memory transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_stage_lsu_align.sv | 56 +++++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - RV32I opcode constants used to classify the incoming slot
//   - load/store funct3 (width/sign) constants
//   - mem_state_t: request FSM states
//   - helpers: misalignment test and "opcode writes rd" decode
package mem_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic result;
    result = 1'b0;
    case (funct3)
      F3_H, F3_HU: result = addr_lo[0];
      F3_W:        result = |addr_lo;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    logic result;
    result = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: purely combinational lane handling for the memory stage.
//   funct3      in  3   width/sign selector of the held access
//   addr_lo     in  2   byte offset within the word
//   store_data  in  32  raw rs2 value
//   load_word   in  32  word returned by memory
//   wstrb       out 4   byte enables for the store
//   wdata       out 32  store data replicated into every candidate lane
//   load_data   out 32  selected lane, sign- or zero-extended
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'd0: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'd1: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = load_word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage after execute.
//   in_*        instruction slot from execute (held stable while out_stall)
//   out_stall   upstream must hold in_* next cycle
//   mem_req_*   data-memory request channel (valid/ready)
//   mem_rsp_*   load response (single-cycle pulse, no backpressure)
//   out_*       registered write-back slot
//   fsm_state   debug view of the request FSM
//
// Handshake: a request transfers on a cycle where mem_req_valid && mem_req_ready.
// Once valid rises, valid and all mem_req_* fields stay constant until that
// transfer (only rst may withdraw it). Responses are only accepted in WAIT.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_noop,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_res,
  input  logic [31:0] in_rs2_data,
  output logic        out_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_noop,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic [31:0] out_res,
  output logic        out_misaligned,
  output mem_state_t  fsm_state
);

  mem_state_t  state, state_next;
  logic        lat_load;
  logic [2:0]  lat_funct3;
  logic [4:0]  lat_rd;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] load_data;

  logic is_load_op, is_store_op, funct3_ok, mem_op_ok, misaligned, start;

  assign is_load_op  = !in_noop && (in_opcode == OPC_LOAD);
  assign is_store_op = !in_noop && (in_opcode == OPC_STORE);
  assign funct3_ok   = is_load_op
                       ? (in_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                       : (in_funct3 inside {F3_B, F3_H, F3_W});
  assign mem_op_ok   = (is_load_op || is_store_op) && funct3_ok;
  assign misaligned  = mem_op_ok && is_misaligned(in_funct3, in_res[1:0]);
  assign start       = mem_op_ok && !misaligned;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Stall drops in the completing cycle so the held slot is not re-accepted.
  always_comb begin
    state_next = state;
    out_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          out_stall  = 1'b1;
        end
      end
      REQ: begin
        out_stall = 1'b1;
        if (mem_req_ready) begin
          state_next = lat_load ? WAIT : IDLE;
          out_stall  = lat_load;
        end
      end
      WAIT: begin
        out_stall = 1'b1;
        if (mem_rsp_valid) begin
          state_next = IDLE;
          out_stall  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_load   <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_rd     <= 5'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else if (state == IDLE && start) begin
      lat_load   <= is_load_op;
      lat_funct3 <= in_funct3;
      lat_rd     <= in_rd;
      lat_addr   <= in_res;
      lat_wdata  <= in_rs2_data;
    end
  end

  lsu_align u_align (
    .funct3     (lat_funct3),
    .addr_lo    (lat_addr[1:0]),
    .store_data (lat_wdata),
    .load_word  (mem_rsp_rdata),
    .wstrb      (mem_req_wstrb),
    .wdata      (mem_req_wdata),
    .load_data  (load_data)
  );

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = {lat_addr[31:2], 2'b00};
  assign mem_req_we    = !lat_load;
  assign fsm_state     = state;

  // Every cycle defaults to a bubble; only a completing slot overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_noop       <= 1'b1;
      out_wb_en      <= 1'b0;
      out_misaligned <= 1'b0;
      out_rd         <= 5'd0;
      out_res        <= 32'd0;
    end else begin
      out_noop       <= 1'b1;
      out_wb_en      <= 1'b0;
      out_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_noop && !is_load_op && !is_store_op) begin
            out_noop  <= 1'b0;
            out_rd    <= in_rd;
            out_res   <= in_res;
            out_wb_en <= writes_rd(in_opcode) && (in_rd != 5'd0);
          end else if (misaligned) begin
            out_misaligned <= 1'b1;
          end
        end
        REQ: begin
          if (!lat_load && mem_req_ready) begin
            out_noop <= 1'b0;
            out_rd   <= lat_rd;
            out_res  <= lat_addr;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            out_noop  <= 1'b0;
            out_rd    <= lat_rd;
            out_res   <= load_data;
            out_wb_en <= (lat_rd != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed steps with a write-back scoreboard.
module tb_mem_stage;
  import mem_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_res;
  logic [31:0] in_rs2_data;
  logic        out_stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        out_noop;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [31:0] out_res;
  logic        out_misaligned;
  mem_state_t  fsm_state;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_noop        (in_noop),
    .in_opcode      (in_opcode),
    .in_funct3      (in_funct3),
    .in_rd          (in_rd),
    .in_res         (in_res),
    .in_rs2_data    (in_rs2_data),
    .out_stall      (out_stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_req_wdata  (mem_req_wdata),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_rdata  (mem_rsp_rdata),
    .out_noop       (out_noop),
    .out_rd         (out_rd),
    .out_wb_en      (out_wb_en),
    .out_res        (out_res),
    .out_misaligned (out_misaligned),
    .fsm_state      (fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  // Entry: {care_rd_res, rd, wb_en, res}
  logic [38:0] exp_q[$];
  logic [38:0] mon_e;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic noop, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] res, input logic [31:0] rs2);
    in_noop     = noop;
    in_opcode   = opc;
    in_funct3   = f3;
    in_rd       = rd;
    in_res      = res;
    in_rs2_data = rs2;
  endtask

  task automatic bubble();
    drive(1'b1, OPC_OP, 3'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic wb, input logic [31:0] res);
    exp_q.push_back({1'b1, rd, wb, res});
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [3:0] exp_strb, input logic [31:0] exp_data);
    mem_req_ready = 1'b1;
    drive(1'b0, OPC_STORE, f3, 5'd1, addr, rs2);
    #1;
    check("st_accept_stall", out_stall, 1'b1);
    check("st_accept_no_req", mem_req_valid, 1'b0);
    exp_q.push_back({1'b0, 5'd0, 1'b0, 32'd0});
    tick();
    #1;
    check("st_req_valid", mem_req_valid, 1'b1);
    check("st_req_addr", mem_req_addr, {addr[31:2], 2'b00});
    check("st_req_we", mem_req_we, 1'b1);
    check("st_req_wstrb", mem_req_wstrb, exp_strb);
    check("st_req_wdata", mem_req_wdata, exp_data);
    check("st_done_stall", out_stall, 1'b0);
    tick();
    mem_req_ready = 1'b0;
    bubble();
    #1;
    check("st_back_idle", fsm_state, IDLE);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] rdata, input int ready_wait, input int rsp_wait,
                         input logic [31:0] exp);
    mem_req_ready = 1'b0;
    drive(1'b0, OPC_LOAD, f3, rd, addr, 32'd0);
    #1;
    check("ld_accept_stall", out_stall, 1'b1);
    push_wb(rd, rd != 5'd0, exp);
    tick();
    for (int i = 0; i < ready_wait; i++) begin
      #1;
      check("ld_hold_valid", mem_req_valid, 1'b1);
      check("ld_hold_addr", mem_req_addr, {addr[31:2], 2'b00});
      check("ld_hold_we", mem_req_we, 1'b0);
      check("ld_hold_stall", out_stall, 1'b1);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    check("ld_req_valid", mem_req_valid, 1'b1);
    check("ld_req_addr", mem_req_addr, {addr[31:2], 2'b00});
    check("ld_req_stall", out_stall, 1'b1);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      #1;
      check("ld_wait_stall", out_stall, 1'b1);
      check("ld_wait_state", fsm_state, WAIT);
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    #1;
    check("ld_rsp_stall", out_stall, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    bubble();
    #1;
    check("ld_back_idle", fsm_state, IDLE);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst && !out_noop) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", out_noop, 1'b1);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[38])
          check("wb_result", {out_rd, out_wb_en, out_res}, mon_e[37:0]);
        else
          check("store_retire_wb_en", out_wb_en, 1'b0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rnd;
    rst = 1'b1;
    bubble();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'd0;
    tick();
    tick();
    check("rst_out_noop", out_noop, 1'b1);
    check("rst_wb_en", out_wb_en, 1'b0);
    check("rst_misaligned", out_misaligned, 1'b0);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_state", fsm_state, IDLE);
    rst = 1'b0;
    mon_en = 1'b1;

    // Non-memory ops: latency 1, no stall
    drive(1'b0, OPC_OP, 3'd0, 5'd5, 32'h0000_1234, 32'd0);
    #1;
    check("add_no_stall", out_stall, 1'b0);
    push_wb(5'd5, 1'b1, 32'h0000_1234);
    tick();
    drive(1'b0, OPC_OP, 3'd0, 5'd0, 32'h0000_0055, 32'd0);
    push_wb(5'd0, 1'b0, 32'h0000_0055);
    tick();
    drive(1'b0, OPC_LUI, 3'd0, 5'd3, 32'hABCD_E000, 32'd0);
    push_wb(5'd3, 1'b1, 32'hABCD_E000);
    tick();
    drive(1'b0, OPC_BRANCH, 3'd0, 5'd9, 32'h0000_0040, 32'd0);
    push_wb(5'd9, 1'b0, 32'h0000_0040);
    tick();
    // Load with illegal funct3: bubble, no request
    drive(1'b0, OPC_LOAD, 3'd3, 5'd2, 32'h0000_0100, 32'd0);
    #1;
    check("badf3_no_stall", out_stall, 1'b0);
    check("badf3_no_req", mem_req_valid, 1'b0);
    tick();
    bubble();
    #1;
    check("badf3_out_noop", out_noop, 1'b1);
    check("badf3_no_misaligned", out_misaligned, 1'b0);
    tick();

    // Stores
    do_store(F3_B, 32'h0000_0103, 32'hAABB_CCDD, 4'b1000, 32'hDDDD_DDDD);
    do_store(F3_H, 32'h0000_0102, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store(F3_W, 32'h0000_0204, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    // Loads
    do_load(F3_B,  5'd7,  32'h0000_0102, 32'h0080_0000, 0, 1, 32'hFFFF_FF80);
    do_load(F3_BU, 5'd8,  32'h0000_0102, 32'h0080_0000, 0, 1, 32'h0000_0080);
    do_load(F3_H,  5'd10, 32'h0000_0102, 32'h8001_1111, 0, 0, 32'hFFFF_8001);
    do_load(F3_HU, 5'd11, 32'h0000_0102, 32'h8001_1111, 0, 0, 32'h0000_8001);
    rnd = $urandom_range(32'hFFFF_FFFF, 0);
    do_load(F3_W,  5'd12, 32'h0000_0200, rnd, 4, $urandom_range(3, 0), rnd);

    // Misaligned accesses: pulse, bubble, no request
    drive(1'b0, OPC_LOAD, F3_W, 5'd6, 32'h0000_0102, 32'd0);
    #1;
    check("mis_lw_no_stall", out_stall, 1'b0);
    check("mis_lw_no_req", mem_req_valid, 1'b0);
    tick();
    bubble();
    #1;
    check("mis_lw_pulse", out_misaligned, 1'b1);
    check("mis_lw_noop", out_noop, 1'b1);
    check("mis_lw_state", fsm_state, IDLE);
    tick();
    check("mis_pulse_ends", out_misaligned, 1'b0);
    drive(1'b0, OPC_STORE, F3_H, 5'd0, 32'h0000_0101, 32'h1111_2222);
    #1;
    check("mis_sh_no_req", mem_req_valid, 1'b0);
    tick();
    bubble();
    #1;
    check("mis_sh_pulse", out_misaligned, 1'b1);
    tick();

    // Reset while waiting for a load response; the late response is dropped
    mem_req_ready = 1'b1;
    drive(1'b0, OPC_LOAD, F3_W, 5'd4, 32'h0000_0300, 32'd0);
    tick();
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("rstw_in_wait", fsm_state, WAIT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bubble();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEAD_BEEF;
    #1;
    check("rstw_state_idle", fsm_state, IDLE);
    check("rstw_no_stall", out_stall, 1'b0);
    check("rstw_no_req", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("rstw_rsp_ignored", out_noop, 1'b1);
    check("rstw_still_idle", fsm_state, IDLE);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
